// File: rtl/pu_mux_bank_pkg.sv
// pu_mux_bank_pkg: shared frame-state encoding and selector range helper
package pu_mux_bank_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } state_t;
  function automatic logic out_of_range(input logic [63:0] field, input int unsigned size);
    return field >= 64'(size);
  endfunction
endpackage

// File: rtl/pu_mux_bank_seq.sv
// pu_mux_bank_seq: frame FSM, index counter and hit/err flags; ports: clk, rst, load/sel strobes, sel_val, oor in; hit, err, latch_en out
module pu_mux_bank_seq
  import pu_mux_bank_pkg::*;
#(
  parameter int MUX_SIZE  = 8,
  parameter int SEL_WIDTH = $clog2(MUX_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 sel,
  input  logic [SEL_WIDTH-1:0] sel_val,
  input  logic                 oor,
  output logic                 hit,
  output logic                 err,
  output logic                 latch_en
);
  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(MUX_SIZE - 1);
  state_t state, state_n;
  logic [SEL_WIDTH-1:0] idx, idx_n, selector, selector_n;
  logic hit_n, err_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      selector <= '0;
      hit      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      selector <= selector_n;
      hit      <= hit_n;
      err      <= err_n;
    end
  end
  // While collecting, err can only hold the out-of-range flag, so gating on it
  // keeps a truncated out-of-range selector from aliasing onto a real index.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    selector_n = selector;
    hit_n      = hit;
    err_n      = err;
    latch_en   = 1'b0;
    if (sel) begin
      selector_n = sel_val;
      idx_n      = '0;
      hit_n      = 1'b0;
      err_n      = oor;
      state_n    = COLLECT;
    end else if (load) begin
      if (state == COLLECT) begin
        latch_en = (idx == selector) && !err;
        hit_n    = hit | latch_en;
        state_n  = (idx == LAST) ? READY : COLLECT;
        idx_n    = (idx == LAST) ? idx : idx + 1'b1;
      end else begin
        err_n = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pu_mux_bank.sv
// pu_mux_bank: selects one word of a MUX_SIZE frame by a leading selector; ports: clk, rst, signal_load/sel/oe, data_in, attr_in in; data_out, attr_out out
module pu_mux_bank
  import pu_mux_bank_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ATTR_WIDTH  = 4,
  parameter int MUX_SIZE    = 8,
  parameter int SEL_WIDTH   = $clog2(MUX_SIZE),
  parameter int SEL_SHIFT   = 0,
  parameter int INVALID_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_load,
  input  logic                  signal_sel,
  input  logic                  signal_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out
);
  logic [DATA_WIDTH-1:0] data_r, data_latch, field;
  logic [ATTR_WIDTH-1:0] attr_r, attr_latch, attr_v;
  logic load_r, sel_r, hit, err, latch_en, oor;
  assign field = data_r >> SEL_SHIFT;
  assign oor   = out_of_range(64'(field), MUX_SIZE);
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
      attr_r <= '0;
      load_r <= 1'b0;
      sel_r  <= 1'b0;
    end else begin
      data_r <= data_in;
      attr_r <= attr_in;
      load_r <= signal_load;
      sel_r  <= signal_sel & signal_load;
    end
  end
  pu_mux_bank_seq #(.MUX_SIZE(MUX_SIZE), .SEL_WIDTH(SEL_WIDTH)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .load     (load_r),
    .sel      (sel_r),
    .sel_val  (field[SEL_WIDTH-1:0]),
    .oor      (oor),
    .hit      (hit),
    .err      (err),
    .latch_en (latch_en)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      data_latch <= '0;
      attr_latch <= '0;
    end else if (latch_en) begin
      data_latch <= data_r;
      attr_latch <= attr_r;
    end
  end
  always_comb begin
    attr_v              = hit ? attr_latch : '0;
    attr_v[INVALID_BIT] = err | ~hit;
  end
  always_ff @(posedge clk) begin
    if (rst || !signal_oe) begin
      data_out <= '0;
      attr_out <= '0;
    end else begin
      data_out <= hit ? data_latch : '0;
      attr_out <= attr_v;
    end
  end
endmodule
